// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects, branch funct3
// codes and control-bundle bit positions.
package riscv_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10,
    AluAuipc = 4'd11
  } alu_op_e;

  localparam logic [1:0] FwdRf    = 2'b00;
  localparam logic [1:0] FwdExMem = 2'b01;
  localparam logic [1:0] FwdMemWb = 2'b10;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  // Bit positions inside id_ex_ctrl = {reg_write, mem_read, mem_write, branch, jal, jalr}
  localparam int unsigned CtrlRegWrite = 5;
  localparam int unsigned CtrlMemRead  = 4;
  localparam int unsigned CtrlMemWrite = 3;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlJal      = 1;
  localparam int unsigned CtrlJalr     = 0;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding/hazard controls and EX/MEM outputs of the execute stage.
interface ex_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rd;
  logic [3:0]      id_ex_alu_op;
  logic            id_ex_alu_src;
  logic [2:0]      id_ex_funct3;
  logic [5:0]      id_ex_ctrl;
  logic [1:0]      forward_rs1_sel;
  logic [1:0]      forward_rs2_sel;
  logic [XLEN-1:0] mem_wb_data;
  logic            mem_stall;
  logic            ex_flush;

  logic            ex_ready;
  logic            ex_mem_valid;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;
  logic [4:0]      ex_mem_rd;
  logic            ex_mem_reg_write;
  logic            ex_mem_mem_read;
  logic            ex_mem_mem_write;
  logic [2:0]      ex_mem_funct3;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;

  modport master (
    output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rd,
           id_ex_alu_op, id_ex_alu_src, id_ex_funct3, id_ex_ctrl, forward_rs1_sel,
           forward_rs2_sel, mem_wb_data, mem_stall, ex_flush,
    input  ex_ready, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_funct3,
           redirect_valid, redirect_pc, misalign_err
  );

  modport slave (
    input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rd,
           id_ex_alu_op, id_ex_alu_src, id_ex_funct3, id_ex_ctrl, forward_rs1_sel,
           forward_rs2_sel, mem_wb_data, mem_stall, ex_flush,
    output ex_ready, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
           ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_funct3,
           redirect_valid, redirect_pc, misalign_err
  );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU; arithmetic wraps, shift amount is b_i[4:0].
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] result_o
);
  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:   result_o = a_i + b_i;
      AluSub:   result_o = a_i - b_i;
      AluSll:   result_o = a_i << shamt;
      AluSlt:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluSltu:  result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      AluXor:   result_o = a_i ^ b_i;
      AluSrl:   result_o = a_i >> shamt;
      AluSra:   result_o = $unsigned($signed(a_i) >>> shamt);
      AluOr:    result_o = a_i | b_i;
      AluAnd:   result_o = a_i & b_i;
      AluPassB: result_o = b_i;
      AluAuipc: result_o = pc_i + imm_i;
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res, result_d, jalr_sum, target;
  logic            br_cond, jump, taken, live, redirect_d, misalign_d, reg_write_d;

  logic            valid_q, reg_write_q, mem_read_q, mem_write_q, redirect_q, misalign_q;
  logic [XLEN-1:0] result_q, store_q, redirect_pc_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;

  // Select 11 falls back to the register file value.
  always_comb begin
    case (bus.forward_rs1_sel)
      FwdExMem: op_a = result_q;
      FwdMemWb: op_a = bus.mem_wb_data;
      default:  op_a = bus.id_ex_rs1_data;
    endcase
    case (bus.forward_rs2_sel)
      FwdExMem: rs2_fwd = result_q;
      FwdMemWb: rs2_fwd = bus.mem_wb_data;
      default:  rs2_fwd = bus.id_ex_rs2_data;
    endcase
  end

  assign op_b = bus.id_ex_alu_src ? bus.id_ex_imm : rs2_fwd;

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i    (bus.id_ex_alu_op),
    .a_i     (op_a),
    .b_i     (op_b),
    .pc_i    (bus.id_ex_pc),
    .imm_i   (bus.id_ex_imm),
    .result_o(alu_res)
  );

  always_comb begin
    br_cond = 1'b0;
    case (bus.id_ex_funct3)
      F3Beq:   br_cond = op_a == rs2_fwd;
      F3Bne:   br_cond = op_a != rs2_fwd;
      F3Blt:   br_cond = $signed(op_a) < $signed(rs2_fwd);
      F3Bge:   br_cond = $signed(op_a) >= $signed(rs2_fwd);
      F3Bltu:  br_cond = op_a < rs2_fwd;
      F3Bgeu:  br_cond = op_a >= rs2_fwd;
      default: br_cond = 1'b0;
    endcase
  end

  assign jump     = bus.id_ex_ctrl[CtrlJal] | bus.id_ex_ctrl[CtrlJalr];
  assign taken    = (bus.id_ex_ctrl[CtrlBranch] & br_cond) | jump;
  assign jalr_sum = op_a + bus.id_ex_imm;
  assign target   = bus.id_ex_ctrl[CtrlJalr] ? {jalr_sum[XLEN-1:1], 1'b0}
                                             : bus.id_ex_pc + bus.id_ex_imm;
  assign result_d = jump ? bus.id_ex_pc + PcStep : alu_res;

  assign live        = bus.id_ex_valid & ~bus.ex_flush;
  assign redirect_d  = live & taken & ~target[1];
  assign misalign_d  = live & taken & target[1];
  assign reg_write_d = live & bus.id_ex_ctrl[CtrlRegWrite] & ~misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      store_q       <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      funct3_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else if (!bus.mem_stall) begin
      valid_q       <= live;
      result_q      <= result_d;
      store_q       <= rs2_fwd;
      rd_q          <= bus.id_ex_rd;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= live & bus.id_ex_ctrl[CtrlMemRead];
      mem_write_q   <= live & bus.id_ex_ctrl[CtrlMemWrite];
      funct3_q      <= bus.id_ex_funct3;
      redirect_q    <= redirect_d;
      redirect_pc_q <= target;
      misalign_q    <= misalign_d;
    end else begin
      // Held EX/MEM must not re-fire a redirect or error on every stalled cycle.
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  assign bus.ex_ready          = ~bus.mem_stall;
  assign bus.ex_mem_valid      = valid_q;
  assign bus.ex_mem_alu_result = result_q;
  assign bus.ex_mem_store_data = store_q;
  assign bus.ex_mem_rd         = rd_q;
  assign bus.ex_mem_reg_write  = reg_write_q;
  assign bus.ex_mem_mem_read   = mem_read_q;
  assign bus.ex_mem_mem_write  = mem_write_q;
  assign bus.ex_mem_funct3     = funct3_q;
  assign bus.redirect_valid    = redirect_q;
  assign bus.redirect_pc       = redirect_pc_q;
  assign bus.misalign_err      = misalign_q;
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset. Ports are named as elsewhere in the codebase:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_ex_valid  in  1  ID/EX holds a live instruction.
REQ-004 id_ex_pc  in  XLEN  instruction PC.
REQ-005 id_ex_rs1_data, id_ex_rs2_data  in  XLEN  register-file operands.
REQ-006 id_ex_imm  in  XLEN  sign-extended immediate.
REQ-007 id_ex_rd  in  5  destination register.
REQ-008 id_ex_alu_op  in  4  ALU operation (package encoding).
REQ-009 id_ex_alu_src  in  1  1 = operand B is imm, 0 = forwarded rs2.
REQ-010 id_ex_funct3  in  3  branch condition / memory size.
REQ-011 id_ex_ctrl  in  6  {reg_write, mem_read, mem_write, branch, jal, jalr}.
REQ-012 forward_rs1_sel, forward_rs2_sel  in  2  00 = register file, 01 = EX/MEM result, 10 = MEM/WB data, 11 treated as 00.
REQ-013 mem_wb_data  in  XLEN  MEM/WB writeback value.
REQ-014 mem_stall  in  1  MEM cannot accept; hold EX/MEM.
REQ-015 ex_flush  in  1  kill the instruction currently in EX.
REQ-016 ex_ready  out  1  = !mem_stall; ID/EX holds when low.
REQ-017 ex_mem_valid  out  1  registered valid.
REQ-018 ex_mem_alu_result  out  XLEN  registered result; also the 01 forward source.
REQ-019 ex_mem_store_data  out  XLEN  forwarded rs2 value, registered.
REQ-020 ex_mem_rd  out  5; ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write  out  1 each; ex_mem_funct3  out  3.
REQ-021 redirect_valid  out  1; redirect_pc  out  XLEN  registered control-flow redirect.
REQ-022 misalign_err  out  1  registered; taken target has bit 1 set.

Function
REQ-023 Operand A SHALL be the rs1 value selected by forward_rs1_sel. Store data SHALL be the rs2 value selected by forward_rs2_sel. Operand B SHALL be id_ex_imm when id_ex_alu_src is 1, else the forwarded rs2 value.
REQ-024 The ALU SHALL support ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB (LUI) and AUIPC (pc+imm).
- Shift amount is B[4:0].
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
REQ-025 When jal or jalr is set, the captured result SHALL be pc+4.
REQ-026 Branch compare SHALL use funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU. funct3 010/011 never taken.
REQ-027 Targets: branch/jal = pc+imm; jalr = (A+imm) with bit 0 cleared.
REQ-028 Capture SHALL occur when !mem_stall. EX/MEM loads all fields, with ex_mem_valid = id_ex_valid & !ex_flush. Latency is 1 cycle.
REQ-029 When mem_stall is high, all EX/MEM outputs SHALL hold and redirect_valid SHALL be 0. Stall beats flush; the flush request is re-presented by its source.
REQ-030 On a captured valid instruction that is taken (branch-true or jump):
- target[1] = 0: redirect_valid pulses high for exactly one cycle with redirect_pc = target.
- target[1] = 1: misalign_err pulses instead, no redirect, and reg_write is suppressed.
REQ-031 A killed or invalid instruction SHALL force reg_write, mem_read, mem_write, redirect_valid and misalign_err to 0 in EX/MEM.
REQ-032 A forward of 01 SHALL use the current ex_mem_alu_result even when ex_mem_valid is 0. Gating is the forwarding unit's job.

Reset
REQ-033 While rst_n is low, every registered output SHALL be 0, including ex_mem_valid, redirect_valid and misalign_err. Release takes effect at the next clk edge. Reset mid-stall SHALL discard the held instruction.
REQ-034 ex_ready SHALL be combinational and SHALL follow mem_stall during reset.

Structure
REQ-035 ALU op codes, forward-select codes, funct3 branch codes and the ctrl bit positions SHALL live in shared package riscv_pkg.
REQ-036 The ALU SHALL be a combinational sub-module named alu. Operand muxing, branch compare and the EX/MEM registers SHALL stay in ex_stage.

Verification
REQ-037 ADD with rs1 = 5, rs2 = 7, sel 00/00 -> next cycle ex_mem_alu_result = 12, ex_mem_valid = 1.
REQ-038 Back-to-back dependent ADD with sel 01, previous result 12, imm 3, alu_src 1 -> result 15. Repeat with sel 10 and mem_wb_data = 100 -> result 103.
REQ-039 BEQ with rs1 = rs2 = 9, pc = 0x100, imm = 0x20 -> redirect_valid high for one cycle, redirect_pc = 0x120. BNE with the same operands -> no redirect.
REQ-040 JALR with A = 0x203, imm = 0 -> target 0x202, so misalign_err = 1, redirect_valid = 0, reg_write = 0.
REQ-041 mem_stall held 3 cycles with a new instruction presented -> EX/MEM unchanged and ex_ready = 0. On release the new instruction is captured. ex_flush together with id_ex_valid -> ex_mem_valid = 0.
REQ-042 Assert rst_n low during a stall -> all registered outputs 0 asynchronously, with no redirect after release.
